// File: rtl/rgb_ctrl_pkg.sv
// Shared definitions for the rgb_ctrl timing path.
//   DivW    : default width of divisor fields and divider counters.
//   state_e : clock-enable controller states.
//             StIdle = stopped
//             StRun  = counting
//             StPend = counting, with a shadow config waiting for the period boundary
package rgb_ctrl_pkg;

  localparam int unsigned DivW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller.
// It emits a one-cycle o_tick at the end of every (div_cur + 1)-cycle period, together with
// o_clk_div, a square wave that toggles on every tick. New divisor and run/stop settings arrive
// over a valid/ready handshake. They take effect only at a period boundary, so a period is
// never truncated.
//
// Ports:
//   clk          system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_cfg_valid  config request valid
//   o_cfg_ready  config can be accepted this cycle (combinational)
//   i_cfg_div    new divisor (period minus one)
//   i_cfg_en     run (1) or stop (0) once the config is applied
//   o_tick       one-cycle pulse at the end of each period
//   o_clk_div    divided clock, toggles on each tick
//   o_active     high while running or pending
//   o_div_cur    divisor currently in force
module clk_div_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = DivW,
  parameter int unsigned DIV_RST = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_cfg_en,
  output logic             o_tick,
  output logic             o_clk_div,
  output logic             o_active,
  output logic [DIV_W-1:0] o_div_cur
);

  localparam logic [DIV_W-1:0] CntOne = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_RST);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic             sh_en_q, sh_en_d;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;
  logic             active_q, active_d;

  logic accept;
  logic terminal;

  assign o_cfg_ready = i_rst_n & (state_q != StPend);
  assign accept      = i_cfg_valid & o_cfg_ready;
  // Terminal compare uses only the divisor in force, never the incoming request.
  assign terminal    = (cnt_q == div_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sh_div_d  = sh_div_q;
    sh_en_d   = sh_en_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_div_d = 1'b0;
        if (accept) begin
          div_d = i_cfg_div;
          if (i_cfg_en) begin
            state_d = StRun;
          end
        end
      end

      StRun, StPend: begin
        if (terminal) begin
          cnt_d     = '0;
          tick_d    = 1'b1;
          clk_div_d = ~clk_div_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end

        if (state_q == StRun) begin
          // A request landing on a terminal edge waits a full period; this terminal is RUN's.
          if (accept) begin
            sh_div_d = i_cfg_div;
            sh_en_d  = i_cfg_en;
            state_d  = StPend;
          end
        end else if (terminal) begin
          div_d = sh_div_q;
          if (sh_en_q) begin
            state_d = StRun;
          end else begin
            state_d   = StIdle;
            clk_div_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DivRst;
      sh_div_q  <= '0;
      sh_en_q   <= 1'b0;
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sh_div_q  <= sh_div_d;
      sh_en_q   <= sh_en_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
      active_q  <= active_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_clk_div = clk_div_q;
  assign o_active  = active_q;
  assign o_div_cur = div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic       o_cfg_ready;
  logic [7:0] i_cfg_div = 8'd0;
  logic       i_cfg_en = 1'b0;
  logic       o_tick;
  logic       o_clk_div;
  logic       o_active;
  logic [7:0] o_div_cur;

  clk_div_ctrl #(
    .DIV_W  (8),
    .DIV_RST(1)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .i_cfg_div  (i_cfg_div),
    .i_cfg_en   (i_cfg_en),
    .o_tick     (o_tick),
    .o_clk_div  (o_clk_div),
    .o_active   (o_active),
    .o_div_cur  (o_div_cur)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int   cyc;
    logic cdv;
  } exp_t;
  exp_t exp_q[$];

  // Expected-schedule state, hand-derived from the divisor and the accept edges.
  bit         running = 1'b0;
  bit         pend = 1'b0;
  bit         pend_en = 1'b0;
  bit         cdv = 1'b0;
  int         last_tick = 0;
  int         period = 0;
  int         pend_b = 0;
  int         pend_period = 0;
  logic [7:0] exp_div = 8'd1;
  logic [7:0] pend_div = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Queue every tick expected at or before edge lim.
  task automatic push_until(input int lim);
    exp_t e;
    while (running && (last_tick + period <= lim)) begin
      e.cyc = last_tick + period;
      cdv   = ~cdv;
      if (pend && e.cyc == pend_b) begin
        exp_div = pend_div;
        pend    = 1'b0;
        if (pend_en) begin
          period = pend_period;
        end else begin
          running = 1'b0;
          cdv     = 1'b0;
        end
      end
      e.cdv     = cdv;
      last_tick = e.cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic reset_model();
    running = 1'b0;
    pend    = 1'b0;
    cdv     = 1'b0;
    exp_div = 8'd1;
  endtask

  task automatic check_state();
    check("active", o_active, running);
    check("cfg_ready", o_cfg_ready, i_rst_n && !pend);
    check("div_cur", o_div_cur, exp_div);
    check("clk_div", o_clk_div, cdv);
  endtask

  // One clock: update the expected schedule after the edge, then check on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!i_rst_n) reset_model();
    else push_until(cyc);
    @(negedge clk);
    check_state();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold valid until accepted; bounded wait.
  task automatic send(input logic [7:0] d, input logic e);
    int guard = 0;
    i_cfg_valid = 1'b1;
    i_cfg_div   = d;
    i_cfg_en    = e;
    while (!o_cfg_ready && guard < 1000) begin
      step();
      guard++;
    end
    if (!o_cfg_ready) begin
      nvec++;
      nerr++;
      $display("FAIL cfg_accept_timeout @cyc %0d: got ready=0, expected ready=1", cyc);
      i_cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_cfg_valid = 1'b0;
    push_until(cyc);
    if (!running) begin
      exp_div = d;
      if (e) begin
        running   = 1'b1;
        last_tick = cyc;
        period    = int'(d) + 1;
        cdv       = 1'b0;
      end
    end else begin
      pend        = 1'b1;
      pend_b      = last_tick + period;
      pend_period = int'(d) + 1;
      pend_en     = e;
      pend_div    = d;
    end
    @(negedge clk);
    check_state();
  endtask

  // Monitor: every tick the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_tick !== 1'b0) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_tick @cyc %0d: got tick=%b, expected no tick", cyc, o_tick);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_cyc", cyc, e.cyc);
        check("tick_clk_div", o_clk_div, e.cdv);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle with no config.
    steps(3);
    i_rst_n = 1'b1;
    #1;
    check("ready_after_release", o_cfg_ready, 1);
    steps(4);

    // div=3 from idle: tick every 4, then shorten to 2 mid-period.
    send(8'd3, 1'b1);
    steps(13);
    send(8'd1, 1'b1);
    steps(10);
    send(8'd2, 1'b1);
    steps(8);

    // Stop while running div=2.
    send(8'd5, 1'b0);
    steps(12);

    // div=0: tick every cycle, then stop.
    send(8'd0, 1'b1);
    steps(6);
    send(8'd255, 1'b0);
    steps(4);

    // Full-range divisor: period 256.
    send(8'd255, 1'b1);
    steps(520);
    send(8'd7, 1'b1);
    send(8'd3, 1'b1);   // held off until the pending config lands
    steps(2);

    // Reset while pending: shadow config must be discarded.
    i_rst_n = 1'b0;
    steps(2);
    i_rst_n = 1'b1;
    steps(12);

    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
